uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 33 +++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
package uart_arb_pkg;

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;

    // UART configuration register bit positions
    localparam int unsigned CFG_ENABLE  = 0;
    localparam int unsigned CFG_RECV_IE = 1;
    localparam int unsigned CFG_SEND_IE = 2;

    typedef enum logic [1:0] {
        ST_INIT_DIV = 2'd0,
        ST_INIT_CFG = 2'd1,
        ST_IDLE     = 2'd2,
        ST_XFER     = 2'd3
    } state_e;

    // Assemble a UART configuration word from its individual controls.
    function automatic logic [WORD_W-1:0] cfg_word(input logic enable,
                                                   input logic recv_ie,
                                                   input logic send_ie);
        logic [WORD_W-1:0] w;
        w              = '0;
        w[CFG_ENABLE]  = enable;
        w[CFG_RECV_IE] = recv_ie;
        w[CFG_SEND_IE] = send_ie;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request strictly after ptr_i, with wrap.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic found;

    // Search indices above the pointer first, then wrap to the low half.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && req_i[j] && (IDX_W'(j) > ptr_i)) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && req_i[j] && (IDX_W'(j) <= ptr_i)) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding several byte streams into one UART TX FIFO.
// Initialises the UART divider and config registers after every reset.
// Optional feature: define UART_ARB_TIMEOUT_EN to revoke a grant whose owner stalls
// for TIMEOUT consecutive cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter logic [31:0] DIV_INIT = 32'd104,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   init_done,
    output logic [3:0]             reg_div_we,
    output logic [WORD_W-1:0]      reg_div_di,
    output logic                   reg_cfg_we,
    output logic [WORD_W-1:0]      reg_cfg_di,
    output logic                   reg_dat_we,
    output logic [WORD_W-1:0]      reg_dat_di,
    input  logic                   reg_dat_wait
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [3:0]         div_we_q, div_we_d;
    logic [WORD_W-1:0]  div_di_q, div_di_d;
    logic               cfg_we_q, cfg_we_d;
    logic [WORD_W-1:0]  cfg_di_q, cfg_di_d;
    logic               init_done_q, init_done_d;

    logic               sel_valid;
    logic               sel_last;
    logic [BYTE_W-1:0]  sel_data;

    logic [NREQ-1:0]    arb_gnt_unused;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

`ifdef UART_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
    logic [31:0]        unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (last_q),
        .gnt_o (arb_gnt_unused),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Select the current owner's stream signals.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Data path towards the UART is a direct pass-through while transferring.
    assign busy       = (state_q == ST_XFER);
    assign reg_dat_we = busy & sel_valid;
    assign reg_dat_di = WORD_W'(sel_data);
    assign grant_id   = grant_q;
    assign init_done  = init_done_q;
    assign reg_div_we = div_we_q;
    assign reg_div_di = div_di_q;
    assign reg_cfg_we = cfg_we_q;
    assign reg_cfg_di = cfg_di_q;

    // Only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (busy && !reg_dat_wait && (grant_q == IDX_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        div_we_d    = '0;
        div_di_d    = '0;
        cfg_we_d    = 1'b0;
        cfg_di_d    = '0;
        init_done_d = init_done_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            ST_INIT_DIV: begin
                div_we_d = 4'hF;
                div_di_d = DIV_INIT;
                state_d  = ST_INIT_CFG;
            end
            ST_INIT_CFG: begin
                cfg_we_d = 1'b1;
                cfg_di_d = cfg_word(1'b1, 1'b0, 1'b0);
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                init_done_d = 1'b1;
                if (arb_any) begin
                    grant_d = arb_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (sel_valid && !reg_dat_wait && sel_last) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
`ifdef UART_ARB_TIMEOUT_EN
                if (sel_valid) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_INIT_DIV;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_INIT_DIV;
            grant_q     <= '0;
            last_q      <= IDX_W'(NREQ - 1);
            div_we_q    <= '0;
            div_di_q    <= '0;
            cfg_we_q    <= 1'b0;
            cfg_di_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            div_we_q    <= div_we_d;
            div_di_q    <= div_di_d;
            cfg_we_q    <= cfg_we_d;
            cfg_di_q    <= cfg_di_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Stall counter for the current owner.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic
// against a packet-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [2:0]        grant_id;
    logic              busy;
    logic              init_done;
    logic [3:0]        reg_div_we;
    logic [31:0]       reg_div_di;
    logic              reg_cfg_we;
    logic [31:0]       reg_cfg_di;
    logic              reg_dat_we;
    logic [31:0]       reg_dat_di;
    logic              reg_dat_wait = 1'b0;

    uart_tx_arbiter #(
        .NREQ     (NREQ),
        .DIV_INIT (32'd104),
        .TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .init_done    (init_done),
        .reg_div_we   (reg_div_we),
        .reg_div_di   (reg_div_di),
        .reg_cfg_we   (reg_cfg_we),
        .reg_cfg_di   (reg_cfg_di),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_wait (reg_dat_wait)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Pending bytes per requester: {last, byte}
    logic [8:0] txq [NREQ][$];
    // Bytes observed entering the UART FIFO
    int         log_id  [$];
    logic [7:0] log_b   [$];
    int         log_cyc [$];

    // Reference model: who owns the UART, and who owned it last
    bit m_busy = 1'b0;
    int m_own  = 0;
    int m_last = NREQ - 1;
    int m_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += txq[i].size();
        return s;
    endfunction

    task automatic clear_log();
        log_id.delete();
        log_b.delete();
        log_cyc.delete();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) txq[i].delete();
        clear_log();
        m_busy = 1'b0;
        m_own  = 0;
        m_last = NREQ - 1;
        m_cnt  = 0;
    endtask

    task automatic push_pkt(input int r, input int len);
        logic [7:0] b;
        for (int j = 0; j < len; j++) begin
            b = 8'($urandom);
            txq[r].push_back({(j == len - 1), b});
        end
    endtask

    task automatic drive_inputs(input logic w, input logic gaps, input logic [NREQ-1:0] mute);
        logic [8:0] h;
        for (int i = 0; i < NREQ; i++) begin
            if (txq[i].size() > 0) begin
                h = txq[i][0];
                req_data[i*8 +: 8] = h[7:0];
                req_last[i]        = h[8];
                req_valid[i]       = !mute[i] && !(gaps && ($urandom_range(3) == 0));
            end else begin
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
                req_valid[i]       = 1'b0;
            end
        end
        reg_dat_wait = w;
    endtask

    // Compare DUT outputs against the model for this cycle, then advance the model.
    task automatic model_step();
        logic [NREQ-1:0] exp_ready;
        logic            exp_we;
        logic [8:0]      h;
        bit              found;
        int              c;
        exp_ready = '0;
        if (m_busy && !reg_dat_wait) exp_ready[m_own] = 1'b1;
        exp_we = m_busy && req_valid[m_own];
        check("busy", busy, m_busy);
        check("req_ready", req_ready, exp_ready);
        check("reg_dat_we", reg_dat_we, exp_we);
        check("div_we_quiet", reg_div_we, 0);
        check("cfg_we_quiet", reg_cfg_we, 0);
        if (m_busy) check("grant_id", grant_id, m_own);
        if (exp_we && txq[m_own].size() > 0) begin
            h = txq[m_own][0];
            check("reg_dat_di", reg_dat_di, {24'd0, h[7:0]});
        end
        if (reg_dat_we && !reg_dat_wait) begin
            log_id.push_back(int'(grant_id));
            log_b.push_back(reg_dat_di[7:0]);
            log_cyc.push_back(cyc);
        end
        if (!m_busy) begin
            if (req_valid != '0) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_last + k) % NREQ;
                    if (!found && req_valid[c]) begin
                        found = 1'b1;
                        m_own = c;
                    end
                end
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            if (req_valid[m_own] && !reg_dat_wait && txq[m_own].size() > 0) begin
                h = txq[m_own].pop_front();
                if (h[8]) begin
                    m_busy = 1'b0;
                    m_last = m_own;
                end
            end
`ifdef UART_ARB_TIMEOUT_EN
            if (req_valid[m_own]) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == TMO) begin
                    m_busy = 1'b0;
                    m_last = m_own;
                end
            end
`endif
        end
    endtask

    task automatic cycle(input logic w, input logic gaps, input logic [NREQ-1:0] mute);
        @(posedge clk);
        #1;
        drive_inputs(w, gaps, mute);
        cyc++;
        @(negedge clk);
        model_step();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (pending() > 0 && n < bound) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        check("drain_bound", pending(), 0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
    endtask

    // Apply reset (current inputs stay for the cycle resetn first goes low), then check init.
    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        reg_dat_wait = 1'b0;
        clear_all();
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_dat_we", reg_dat_we, 0);
        check("rst_div_we", reg_div_we, 0);
        check("rst_cfg_we", reg_cfg_we, 0);
        check("rst_init_done", init_done, 0);
        check("rst_grant_id", grant_id, 0);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("init1_div_we", reg_div_we, 4'hF);
        check("init1_div_di", reg_div_di, 32'd104);
        check("init1_cfg_we", reg_cfg_we, 0);
        check("init1_done", init_done, 0);
        @(posedge clk);
        #1;
        check("init2_cfg_we", reg_cfg_we, 1);
        check("init2_cfg_di", reg_cfg_di, 32'h1);
        check("init2_div_we", reg_div_we, 0);
        check("init2_done", init_done, 0);
        @(posedge clk);
        #1;
        check("init3_done", init_done, 1);
        check("init3_cfg_we", reg_cfg_we, 0);
        check("init3_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         hold;
        int         c0;
        int         r;
        logic       w;
        logic [7:0] exp_b [$];
        int         exp_ord [6];
        logic [8:0] h;

        // Reset and UART initialisation
        do_reset(3);

        // Two simultaneous 3-byte packets: requester 0 then 2, one idle gap
        clear_log();
        exp_b.delete();
        push_pkt(0, 3);
        push_pkt(2, 3);
        for (int j = 0; j < 3; j++) begin h = txq[0][j]; exp_b.push_back(h[7:0]); end
        for (int j = 0; j < 3; j++) begin h = txq[2][j]; exp_b.push_back(h[7:0]); end
        c0 = cyc + 1;
        drain(40);
        check("p2_count", log_b.size(), 6);
        if (log_b.size() == 6) begin
            for (int j = 0; j < 6; j++) begin
                check("p2_id", log_id[j], (j < 3) ? 0 : 2);
                check("p2_byte", log_b[j], exp_b[j]);
            end
            check("p2_latency", log_cyc[0] - c0, 1);
            check("p2_burst", log_cyc[2] - log_cyc[0], 2);
            check("p2_gap", log_cyc[3] - log_cyc[2], 2);
        end

        // 20-byte packet with the FIFO full for 5 cycles at byte 16
        clear_log();
        exp_b.delete();
        push_pkt(1, 20);
        for (int j = 0; j < 20; j++) begin h = txq[1][j]; exp_b.push_back(h[7:0]); end
        hold = 0;
        n = 0;
        while (txq[1].size() > 0 && n < 100) begin
            w = (log_b.size() == 15) && (hold < 5);
            if (w) hold++;
            cycle(w, 1'b0, '0);
            n++;
        end
        drain(10);
        check("w_count", log_b.size(), 20);
        if (log_b.size() == 20) begin
            for (int j = 0; j < 20; j++) begin
                check("w_byte", log_b[j], exp_b[j]);
                check("w_id", log_id[j], 1);
            end
            check("w_stall", log_cyc[15] - log_cyc[14], 6);
        end

        // Reset while a packet is mid-transfer
        clear_log();
        push_pkt(3, 5);
        n = 0;
        while (log_b.size() < 1 && n < 20) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        check("mid_first_byte", log_b.size(), 1);
        do_reset(2);

        // All requesters continuously valid with 1-byte packets
        clear_log();
        exp_ord = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NREQ; i++) begin
            push_pkt(i, 1);
            push_pkt(i, 1);
            push_pkt(i, 1);
        end
        n = 0;
        while (log_b.size() < 6 && n < 40) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        check("rr_count", (log_b.size() >= 6), 1);
        if (log_b.size() >= 6) begin
            for (int j = 0; j < 6; j++) check("rr_order", log_id[j], exp_ord[j]);
            for (int j = 0; j < 5; j++) check("rr_spacing", log_cyc[j+1] - log_cyc[j], 2);
        end
        drain(100);

        // Owner stalls mid-packet while others wait
        clear_log();
        push_pkt(0, 10);
        n = 0;
        while (log_b.size() < 2 && n < 20) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        push_pkt(1, 3);
        push_pkt(2, 3);
        for (int j = 0; j < 300; j++) cycle(1'b0, 1'b0, 4'b0001);
`ifdef UART_ARB_TIMEOUT_EN
        check("tmo_count", log_b.size(), 8);
        if (log_b.size() >= 3) check("tmo_next_owner", log_id[2], 1);
`else
        check("hold_count", log_b.size(), 2);
        check("hold_busy", busy, 1);
        check("hold_grant", grant_id, 0);
`endif
        drain(200);

        // Random traffic with valid gaps and FIFO back-pressure
        for (int j = 0; j < 1500; j++) begin
            if ($urandom_range(7) == 0) begin
                r = int'($urandom_range(NREQ - 1));
                if (txq[r].size() < 12) push_pkt(r, int'($urandom_range(5, 1)));
            end
            w = ($urandom_range(3) == 0);
            cycle(w, 1'b1, '0);
        end
        drain(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
